// File: rtl/ones_expand.sv
// Serial expander: emits a WIDTH-bit thermometer frame from a ones count.
// Define ONES_EXPAND_PARITY_EN to append an odd-count parity bit per frame.
module ones_expand #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [CW-1:0]    count_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             ser_o,
  output logic             frame_o,
  output logic             done_o,
  output logic             err_o,
  output logic [WIDTH-1:0] word_o
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

`ifdef ONES_EXPAND_PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx, cnt_inc;
  logic [CW-1:0]    n, n_nx, cl;
  logic [WIDTH-1:0] word_nx;
  logic             ready_nx, ser_nx, frame_nx;
  logic             done_nx, err_nx;

  assign cnt_inc = cnt + CW'(1);
  assign cl      = (count_i > CW'(WIDTH)) ? CW'(WIDTH) : count_i;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    n_nx     = n;
    word_nx  = word_o;
    ready_nx = 1'b0;
    ser_nx   = 1'b0;
    frame_nx = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        ready_nx = 1'b1;
        if (valid_i && ready_o) begin
          n_nx = cl;
          for (int i = 0; i < WIDTH; i++)
            word_nx[i] = CW'(i) < cl;
          err_nx   = count_i > CW'(WIDTH);
          cnt_nx   = '0;
          ser_nx   = cl != '0;
          frame_nx = 1'b1;
          ready_nx = 1'b0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CW'(LAST)) begin
          done_nx  = 1'b1;
          state_nx = DONE;
        end else begin
          cnt_nx   = cnt_inc;
          frame_nx = 1'b1;
          ser_nx   = cnt_inc < n;
`ifdef ONES_EXPAND_PARITY_EN
          // trailing cycle carries parity of the clamped count
          if (cnt_inc == CW'(WIDTH))
            ser_nx = n[0];
`endif
        end
      end
      DONE: begin
        ready_nx = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        ready_nx = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      n       <= '0;
      word_o  <= '0;
      ready_o <= 1'b1;
      ser_o   <= 1'b0;
      frame_o <= 1'b0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      n       <= n_nx;
      word_o  <= word_nx;
      ready_o <= ready_nx;
      ser_o   <= ser_nx;
      frame_o <= frame_nx;
      done_o  <= done_nx;
      err_o   <= err_nx;
    end
  end

endmodule

// File: tb/tb_ones_expand.sv
// Bench for ones_expand: directed scenarios plus random traffic,
// checked against a per-cycle queue of expected frame bits.
module tb_ones_expand;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);
`ifdef ONES_EXPAND_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic [CW-1:0]    count_i;
  logic             valid_i;
  logic             ready_o;
  logic             ser_o;
  logic             frame_o;
  logic             done_o;
  logic             err_o;
  logic [WIDTH-1:0] word_o;

  int total = 0;
  int bad   = 0;

  // {ser, frame, done} expected for each upcoming cycle
  logic [2:0]       q[$];
  logic [WIDTH-1:0] word_exp = '0;
  logic             err_exp  = 1'b0;

  ones_expand #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .count_i (count_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .ser_o   (ser_o),
    .frame_o (frame_o),
    .done_o  (done_o),
    .err_o   (err_o),
    .word_o  (word_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h",
               tag, $time, got, exp);
    end
  endtask

  task automatic step(input logic rst,
                      input logic v,
                      input logic [CW-1:0] c);
    int n;
    logic rdy;
    logic [2:0] e;
    reset_n = rst;
    valid_i = v;
    count_i = c;
    @(posedge clk);
    rdy = q.size() == 0;
    if (!rst) begin
      q.delete();
      word_exp = '0;
      err_exp  = 1'b0;
    end else begin
      if (q.size() != 0)
        void'(q.pop_front());
      err_exp = 1'b0;
      if (v && rdy) begin
        n = (int'(c) > WIDTH) ? WIDTH : int'(c);
        err_exp = int'(c) > WIDTH;
        word_exp = WIDTH'((64'd1 << n) - 64'd1);
        for (int i = 0; i < WIDTH; i++)
          q.push_back({i < n, 1'b1, 1'b0});
        if (FL > WIDTH)
          q.push_back({n[0], 1'b1, 1'b0});
        q.push_back(3'b001);
      end
    end
    #1;
    e = (q.size() != 0) ? q[0] : 3'b000;
    chk("ready", ready_o, q.size() == 0);
    chk("ser",   ser_o,   e[2]);
    chk("frame", frame_o, e[1]);
    chk("done",  done_o,  e[0]);
    chk("err",   err_o,   err_exp);
    chk("word",  word_o,  word_exp);
  endtask

  initial begin
    reset_n = 1'b0;
    valid_i = 1'b0;
    count_i = '0;
    repeat (3) step(1'b0, 1'b1, CW'(3));
    repeat (3) step(1'b1, 1'b0, CW'(3));
    step(1'b1, 1'b1, CW'(3));
    repeat (FL + 2) step(1'b1, 1'b0, '0);
    // count 0 then full count, valid held high
    repeat (FL + 2) step(1'b1, 1'b1, CW'(0));
    repeat (FL + 3) step(1'b1, 1'b1, CW'(WIDTH));
    step(1'b1, 1'b0, '0);
    // clamp case
    step(1'b1, 1'b1, CW'(12));
    repeat (FL + 2) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, CW'(4));
    repeat (FL + 2) step(1'b1, 1'b0, '0);
    // ignored request, then abort mid-frame
    step(1'b1, 1'b1, CW'(5));
    repeat (3) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, CW'(2));
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    repeat (FL + 3) step(1'b1, 1'b0, '0);
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 49) != 0,
           $urandom_range(0, 1) == 1,
           CW'($urandom_range(0, (1 << CW) - 1)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ones_expand.md
Name: ones_expand

Overview:
Serial expander that reverses the ones-count function: it takes a population count and regenerates a frame of WIDTH bits containing exactly that many ones.
- Ones are emitted first (thermometer order), one bit per clock.
- A parallel thermometer word is produced alongside the serial stream.
- Sits downstream of ones-count logic, to rebuild test patterns or drive serial links from a count value.

Parameters:
WIDTH, 8, frame length in bits (>=2)
CW, $clog2(WIDTH+1), width of count input (derived; do not override)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  synchronous active-low reset
count_i  input  CW  number of ones to emit
valid_i  input  1  count_i valid request
ready_o  output  1  block can accept a request
ser_o  output  1  serial frame bit
frame_o  output  1  high while ser_o carries a valid frame bit
done_o  output  1  one-cycle pulse after last frame bit
err_o  output  1  one-cycle pulse: count_i > WIDTH was accepted (clamped)
word_o  output  WIDTH  thermometer word of last accepted count, LSBs set

Behaviour:
- Reset: one clock, synchronous active-low reset (clk, reset_n); reset_n sampled on rising clk only.
- Reset values: state=IDLE, ready_o=1, ser_o=0, frame_o=0, done_o=0, err_o=0, word_o=0, internal bit counter=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - ready_o=1; frame_o=0; ser_o=0.
  - On valid_i&&ready_o at edge T: latch n=min(count_i,WIDTH); word_o <= (1<<n)-1.
  - err_o=1 in cycle T+1 if count_i>WIDTH, else 0.
  - Bit counter <= 0; go to SHIFT.
- SHIFT:
  - ready_o=0; frame_o=1.
  - ser_o=1 while bit counter < n, else 0.
  - Counter increments each cycle.
  - When counter==WIDTH-1, go to DONE next edge.
  - Frame bits occupy cycles T+1..T+WIDTH.
- DONE (cycle T+WIDTH+1):
  - done_o=1, frame_o=0, ser_o=0, ready_o=0; go to IDLE.
  - ready_o=1 again at T+WIDTH+2.
  - Minimum request spacing: WIDTH+2 cycles.
- valid_i while ready_o=0: ignored, not queued; count_i is don't-care.
- n=0: all-zero frame, still WIDTH cycles with frame_o=1, done_o pulses.
- n=WIDTH: all-ones frame.
- word_o holds its value until the next accept; it is not cleared by DONE.
- Reset mid-frame: next edge returns all outputs to reset values; no done_o for the aborted frame; word_o cleared.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
Macro ONES_EXPAND_PARITY_EN.
- Defined:
  - A parity bit equal to n[0] (odd ones-count parity) is appended after the WIDTH data bits.
  - Frame length becomes WIDTH+1 and frame_o stays high for the parity cycle.
  - done_o moves to T+WIDTH+2; ready_o returns at T+WIDTH+3.
- Undefined: frame is exactly WIDTH bits, timing as above; no parity logic is synthesized.

Test Plan:
1. Reset: hold reset_n=0 for 3 clks with valid_i=1 -> ready_o=1, frame_o=0, ser_o=0, done_o=0, err_o=0, word_o=8'h00 throughout; no frame after release until a new valid.
2. WIDTH=8, count_i=3 accepted at T -> ser_o=1,1,1,0,0,0,0,0 in T+1..T+8 with frame_o=1; word_o=8'h07 from T+1; done_o=1 only at T+9; ready_o=1 at T+10.
3. count_i=0 and count_i=8 back-to-back, valid_i held high -> second accept exactly at T+10; frames 00000000 then 11111111; word_o 8'h00 then 8'hFF; done_o pulses at T+9 and T+19.
4. count_i=12 (CW=4) -> err_o=1 at T+1 only; frame all ones; word_o=8'hFF.
5. count_i=5, then valid_i=1 with count_i=2 at T+4 -> second request ignored, frame 11111000 unaltered; reset_n=0 at T+6 -> at T+7 frame_o=0, word_o=0, and no done_o pulse.
6. With ONES_EXPAND_PARITY_EN, count_i=3 -> ser_o=1,1,1,0,0,0,0,0,1 over T+1..T+9; done_o at T+10. With count_i=4 the parity bit is 0.
